// File: rtl/issue_collapse_queue.sv
// Collapsing 4-wide issue queue: oldest four entries on slots 0..3, out-of-order acks, survivors close up.
// Optional feature macro ISSUE_Q_PERF_EN builds the blocked-enqueue and issued-entry counters.
package issue_q_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  trans_id;
    logic [3:0]  fu;
    logic [7:0]  op;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rd;
  } scoreboard_entry_t;
endpackage

module issue_collapse_queue
  import issue_q_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned NR_PORTS = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 flush_i,
  input  scoreboard_entry_t [NR_PORTS-1:0]     in_instr_i,
  input  logic [NR_PORTS-1:0]                  in_valid_i,
  output logic                                 in_ready_o,
  output scoreboard_entry_t [NR_PORTS-1:0]     issue_instr_o,
  output logic [NR_PORTS-1:0]                  issue_instr_valid_o,
  input  logic [NR_PORTS-1:0]                  issue_ack_i,
  output logic [$clog2(DEPTH+1)-1:0]           count_o,
  output logic                                 empty_o,
  output logic                                 full_o,
  output logic [31:0]                          perf_full_cycles_o,
  output logic [31:0]                          perf_issued_o
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned AW = $clog2(DEPTH);

  scoreboard_entry_t q_reg [DEPTH];
  scoreboard_entry_t q_next [DEPTH];
  logic [CW-1:0]     count_reg, count_next;
  logic [NR_PORTS-1:0] eff_ack, accept;
  logic [CW-1:0]     ack_cnt, acc_cnt;
  logic [AW-1:0]     shift, enq_ptr;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NR_PORTS; gi++) begin : g_slot
      assign issue_instr_o[gi]       = q_reg[gi];
      assign issue_instr_valid_o[gi] = (CW'(gi) < count_reg);
    end
  endgenerate

  // Readiness looks only at the registered count, so acks never open the gate in the same cycle.
  assign in_ready_o = (count_reg <= CW'(DEPTH - NR_PORTS));
  assign count_o    = count_reg;
  assign empty_o    = (count_reg == '0);
  assign full_o     = (count_reg == CW'(DEPTH));

  assign eff_ack = issue_ack_i & issue_instr_valid_o;
  assign accept  = in_ready_o ? in_valid_i : '0;
  assign ack_cnt = CW'(popcnt4(eff_ack));
  assign acc_cnt = CW'(popcnt4(accept));

  always_comb begin
    q_next  = q_reg;
    shift   = '0;
    enq_ptr = '0;
    // Head slots: each survivor moves down by the number of acked slots in front of it.
    for (int j = 0; j < NR_PORTS; j++) begin
      if (issue_instr_valid_o[j] && !eff_ack[j]) q_next[AW'(j) - shift] = q_reg[j];
      if (eff_ack[j]) shift = shift + AW'(1);
    end
    for (int j = NR_PORTS; j < DEPTH; j++) begin
      if (CW'(j) < count_reg) q_next[AW'(j) - AW'(ack_cnt)] = q_reg[j];
    end
    // Accepted lanes pack behind all survivors in lane order, skipping idle lanes.
    enq_ptr = AW'(count_reg - ack_cnt);
    for (int l = 0; l < NR_PORTS; l++) begin
      if (accept[l]) begin
        q_next[enq_ptr] = in_instr_i[l];
        enq_ptr         = enq_ptr + AW'(1);
      end
    end
    count_next = flush_i ? '0 : (count_reg - ack_cnt + acc_cnt);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) q_reg[i] <= '0;
    end else begin
      count_reg <= count_next;
      for (int i = 0; i < DEPTH; i++) q_reg[i] <= q_next[i];
    end
  end

`ifdef ISSUE_Q_PERF_EN
  logic [31:0] perf_full_reg, perf_issued_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_full_reg   <= '0;
      perf_issued_reg <= '0;
    end else if (!flush_i) begin
      if (!in_ready_o && |in_valid_i) perf_full_reg <= perf_full_reg + 32'd1;
      perf_issued_reg <= perf_issued_reg + 32'(ack_cnt);
    end
  end

  assign perf_full_cycles_o = perf_full_reg;
  assign perf_issued_o      = perf_issued_reg;
`else
  assign perf_full_cycles_o = 32'h0;
  assign perf_issued_o      = 32'h0;
`endif

  count_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni) count_reg <= CW'(DEPTH));

endmodule

// File: tb/tb_issue_collapse_queue.sv
// Directed bench for issue_collapse_queue; expected values are hand-computed per scenario.
module tb_issue_collapse_queue;
  import issue_q_pkg::*;

  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b0;
  logic                    flush_i = 1'b0;
  scoreboard_entry_t [3:0] in_instr_i = '0;
  logic [3:0]              in_valid_i = '0;
  logic                    in_ready_o;
  scoreboard_entry_t [3:0] issue_instr_o;
  logic [3:0]              issue_instr_valid_o;
  logic [3:0]              issue_ack_i = '0;
  logic [4:0]              count_o;
  logic                    empty_o, full_o;
  logic [31:0]             perf_full_cycles_o, perf_issued_o;

  int total = 0;
  int bad   = 0;

  issue_collapse_queue dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_instr_i(in_instr_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .issue_instr_o(issue_instr_o), .issue_instr_valid_o(issue_instr_valid_o),
    .issue_ack_i(issue_ack_i), .count_o(count_o), .empty_o(empty_o), .full_o(full_o),
    .perf_full_cycles_o(perf_full_cycles_o), .perf_issued_o(perf_issued_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic scoreboard_entry_t mk(input int id);
    scoreboard_entry_t e;
    e          = '0;
    e.pc       = 32'h1000 + 32'(id) * 32'd4;
    e.trans_id = 4'(id);
    e.op       = 8'(id + 8'h40);
    e.rd       = 6'(id);
    return e;
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock of stimulus; lane l carries entry base_id+l.
  task automatic cyc(input logic [3:0] v, input logic [3:0] ack, input logic fl, input int base_id);
    for (int l = 0; l < 4; l++) in_instr_i[l] = mk(base_id + l);
    in_valid_i  = v;
    issue_ack_i = ack;
    flush_i     = fl;
    @(posedge clk_i);
    #1;
    in_valid_i  = '0;
    issue_ack_i = '0;
    flush_i     = 1'b0;
    in_instr_i  = '0;
    $display("txn valid=%b ack=%b flush=%b -> count=%0d slots_valid=%b", v, ack, fl, count_o, issue_instr_valid_o);
  endtask

  logic [31:0] exp_full, exp_issued;

  initial begin
`ifdef ISSUE_Q_PERF_EN
    exp_full = 32'd3; exp_issued = 32'd5;
`else
    exp_full = 32'd0; exp_issued = 32'd0;
`endif
    // Reset state
    #12;
    check("rst_valid", issue_instr_valid_o, 4'b0000);
    check("rst_slot0", issue_instr_o[0], 0);
    check("rst_count", count_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_full", full_o, 0);
    check("rst_ready", in_ready_o, 1);
    rst_ni = 1'b1;

    // Four-lane enqueue visible next cycle
    cyc(4'b1111, 4'b0000, 1'b0, 1);
    check("t1_valid", issue_instr_valid_o, 4'b1111);
    check("t1_s0", issue_instr_o[0], mk(1));
    check("t1_s3", issue_instr_o[3], mk(4));
    check("t1_count", count_o, 4);
    check("t1_empty", empty_o, 0);

    // Out-of-order ack collapses toward the head
    cyc(4'b0011, 4'b0000, 1'b0, 5);
    check("t2_pre_count", count_o, 6);
    cyc(4'b0000, 4'b0101, 1'b0, 0);
    check("t2_s0", issue_instr_o[0], mk(2));
    check("t2_s1", issue_instr_o[1], mk(4));
    check("t2_s2", issue_instr_o[2], mk(5));
    check("t2_s3", issue_instr_o[3], mk(6));
    check("t2_count", count_o, 4);

    // Ack all four while enqueuing two: new entries land at the head
    cyc(4'b0011, 4'b1111, 1'b0, 7);
    check("t7_s0", issue_instr_o[0], mk(7));
    check("t7_s1", issue_instr_o[1], mk(8));
    check("t7_count", count_o, 2);
    check("t7_valid", issue_instr_valid_o, 4'b0011);

    // Non-contiguous lanes pack in lane order
    cyc(4'b1010, 4'b0000, 1'b0, 10);
    check("nc_s2", issue_instr_o[2], mk(11));
    check("nc_s3", issue_instr_o[3], mk(13));
    check("nc_count", count_o, 4);

    // Fill to 13, then blocked enqueue with a head ack
    cyc(4'b0000, 4'b0000, 1'b1, 0);
    check("fl_count", count_o, 0);
    cyc(4'b1111, 4'b0000, 1'b0, 1);
    cyc(4'b1111, 4'b0000, 1'b0, 5);
    cyc(4'b1111, 4'b0000, 1'b0, 9);
    cyc(4'b0001, 4'b0000, 1'b0, 13);
    check("t3_count13", count_o, 13);
    check("t3_ready13", in_ready_o, 0);
    cyc(4'b1111, 4'b0001, 1'b0, 20);
    check("t3_count", count_o, 12);
    check("t3_ready", in_ready_o, 1);
    check("t3_s0", issue_instr_o[0], mk(2));
    cyc(4'b1111, 4'b0000, 1'b0, 24);
    check("t3_full", full_o, 1);
    check("t3_ready_full", in_ready_o, 0);

    // Asynchronous reset mid-operation
    #2 rst_ni = 1'b0;
    #1;
    check("ar_count", count_o, 0);
    check("ar_ready", in_ready_o, 1);
    check("ar_valid", issue_instr_valid_o, 4'b0000);
    #2 rst_ni = 1'b1;
    check("ar_perf_full", perf_full_cycles_o, 0);
    check("ar_perf_iss", perf_issued_o, 0);

    // Perf: fill, three blocked cycles, then five acks
    for (int c = 0; c < 4; c++) cyc(4'b1111, 4'b0000, 1'b0, 4 * c);
    check("p_full", full_o, 1);
    for (int c = 0; c < 3; c++) cyc(4'b1111, 4'b0000, 1'b0, 0);
    check("p_count_held", count_o, 16);
    cyc(4'b0000, 4'b1111, 1'b0, 0);
    cyc(4'b0000, 4'b0001, 1'b0, 0);
    check("p_count", count_o, 11);
    check("p_full_cycles", perf_full_cycles_o, exp_full);
    check("p_issued", perf_issued_o, exp_issued);

    // Flush overrides enqueue and ack; perf counters keep their values
    cyc(4'b0011, 4'b0001, 1'b1, 30);
    check("t5_count", count_o, 0);
    check("t5_valid", issue_instr_valid_o, 4'b0000);
    check("t5_empty", empty_o, 1);
    check("t5_perf_iss", perf_issued_o, exp_issued);

    // Acks on empty slots are ignored
    cyc(4'b0011, 4'b0000, 1'b0, 1);
    cyc(4'b0000, 4'b1110, 1'b0, 0);
    check("t4_count", count_o, 1);
    check("t4_s0", issue_instr_o[0], mk(1));
    check("t4_valid", issue_instr_valid_o, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
